// File: rtl/tx_data_buffer.sv
// tx_data_buffer: FWFT byte buffer feeding the USB full-speed TX encoder.
// Optional sticky drop flag on port err when TX_DATA_BUFFER_ERR_EN is defined.
module tx_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_enable,
  output logic [DATA_W-1:0] r_data,
  input  logic              flush,
  output logic              empty,
  output logic              full,
`ifdef TX_DATA_BUFFER_ERR_EN
  output logic [CW-1:0]     count,
  output logic              err
`else
  output logic [CW-1:0]     count
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              w_acc;
  logic              r_acc;

  // status flags come straight off the count register
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
  end

  // flush outranks both requests; illegal requests are dropped here
  always_comb begin
    w_acc = w_enable & ~full & ~flush;
    r_acc = r_enable & ~empty & ~flush;
  end

  // head entry falls through; zero while nothing is stored
  always_comb begin
    r_data = '0;
    if (!empty) r_data = mem[rptr];
  end

  // storage array, no reset needed on contents
  always_ff @(posedge clk) begin
    if (w_acc) mem[wptr] <= w_data;
  end

  // write pointer, wraps naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
    end else if (flush) begin
      wptr <= '0;
    end else if (w_acc) begin
      wptr <= wptr + AW'(1);
    end
  end

  // read pointer, wraps naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
    end else if (flush) begin
      rptr <= '0;
    end else if (r_acc) begin
      rptr <= rptr + AW'(1);
    end
  end

  // occupancy: simultaneous accepts cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({w_acc, r_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef TX_DATA_BUFFER_ERR_EN
  logic drop;

  always_comb begin
    drop = ~flush & ((w_enable & full) | (r_enable & empty));
  end

  // sticky drop indicator, cleared by flush even on a coincident drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (flush) begin
      err <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_data_buffer.sv
// tb_tx_data_buffer: directed tests for tx_data_buffer.
// Define TX_DATA_BUFFER_ERR_EN to also cover the err flag.
module tb_tx_data_buffer;

  logic       clk;
  logic       rst;
  logic       w_enable;
  logic [7:0] w_data;
  logic       r_enable;
  logic [7:0] r_data;
  logic       flush;
  logic       empty;
  logic       full;
  logic [6:0] count;
`ifdef TX_DATA_BUFFER_ERR_EN
  logic       err;
`endif

  int vec;
  int errs;

  tx_data_buffer #(.DEPTH(64), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_enable (w_enable),
    .w_data   (w_data),
    .r_enable (r_enable),
    .r_data   (r_data),
    .flush    (flush),
    .empty    (empty),
    .full     (full),
`ifdef TX_DATA_BUFFER_ERR_EN
    .count    (count),
    .err      (err)
`else
    .count    (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of inputs, land 1 time unit after the edge
  task automatic step(input logic we, input logic [7:0] wd,
                      input logic re, input logic fl);
    w_enable = we;
    w_data   = wd;
    r_enable = re;
    flush    = fl;
    @(posedge clk);
    #1;
    w_enable = 1'b0;
    w_data   = 8'h00;
    r_enable = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      vec++;
      if (empty !== 1'b1 || full !== 1'b0) begin
        errs++;
        $display("FAIL reset_flags: empty=%b full=%b want 1 0", empty, full);
      end
      vec++;
      if (count !== 7'd0 || r_data !== 8'h00) begin
        errs++;
        $display("FAIL reset_data: count=%0d r_data=%h want 0 00", count, r_data);
      end
`ifdef TX_DATA_BUFFER_ERR_EN
      vec++;
      if (err !== 1'b0) begin
        errs++;
        $display("FAIL reset_err: err=%b want 0", err);
      end
`endif
    end
  endtask

  task automatic test_basic;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    vec++;
    if (r_data !== 8'hA5 || count !== 7'd1 || empty !== 1'b0) begin
      errs++;
      $display("FAIL basic_w1: r_data=%h count=%0d empty=%b want a5 1 0",
               r_data, count, empty);
    end
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    vec++;
    if (r_data !== 8'hA5 || count !== 7'd2) begin
      errs++;
      $display("FAIL basic_w2: r_data=%h count=%0d want a5 2", r_data, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vec++;
    if (r_data !== 8'h3C || count !== 7'd1) begin
      errs++;
      $display("FAIL basic_p1: r_data=%h count=%0d want 3c 1", r_data, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vec++;
    if (empty !== 1'b1 || count !== 7'd0 || r_data !== 8'h00) begin
      errs++;
      $display("FAIL basic_p2: empty=%b count=%0d r_data=%h want 1 0 00",
               empty, count, r_data);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 64; i++) begin
      vec++;
      if (full !== 1'b0 || count !== 7'(i)) begin
        errs++;
        $display("FAIL fill_progress: full=%b count=%0d want 0 %0d", full, count, i);
      end
      step(1'b1, 8'(i), 1'b0, 1'b0);
    end
    vec++;
    if (full !== 1'b1 || count !== 7'd64 || r_data !== 8'h00) begin
      errs++;
      $display("FAIL fill_full: full=%b count=%0d r_data=%h want 1 64 00",
               full, count, r_data);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    vec++;
    if (count !== 7'd64 || full !== 1'b1) begin
      errs++;
      $display("FAIL fill_drop: count=%0d full=%b want 64 1", count, full);
    end
`ifdef TX_DATA_BUFFER_ERR_EN
    vec++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL fill_err: err=%b want 1", err);
    end
`endif
    for (int i = 0; i < 64; i++) begin
      vec++;
      if (r_data !== 8'(i)) begin
        errs++;
        $display("FAIL drain_data: r_data=%h want %h", r_data, 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    vec++;
    if (empty !== 1'b1 || count !== 7'd0) begin
      errs++;
      $display("FAIL drain_empty: empty=%b count=%0d want 1 0", empty, count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef TX_DATA_BUFFER_ERR_EN
    vec++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL flush_err_clear: err=%b want 0", err);
    end
`endif
  endtask

  task automatic test_full_both;
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    vec++;
    if (count !== 7'd63 || r_data !== 8'h01 || full !== 1'b0) begin
      errs++;
      $display("FAIL full_both: count=%0d r_data=%h full=%b want 63 01 0",
               count, r_data, full);
    end
    for (int i = 1; i < 64; i++) begin
      vec++;
      if (r_data !== 8'(i)) begin
        errs++;
        $display("FAIL full_both_drain: r_data=%h want %h", r_data, 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    vec++;
    if (empty !== 1'b1) begin
      errs++;
      $display("FAIL full_both_empty: empty=%b want 1", empty);
    end
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    vec++;
    if (count !== 7'd1 || r_data !== 8'h5A) begin
      errs++;
      $display("FAIL empty_both: count=%0d r_data=%h want 1 5a", count, r_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vec++;
    if (empty !== 1'b1) begin
      errs++;
      $display("FAIL empty_both_pop: empty=%b want 1", empty);
    end
  endtask

  task automatic test_flush;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vec++;
    if (count !== 7'd0 || empty !== 1'b1) begin
      errs++;
      $display("FAIL underflow: count=%0d empty=%b want 0 1", count, empty);
    end
`ifdef TX_DATA_BUFFER_ERR_EN
    vec++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL underflow_err: err=%b want 1", err);
    end
`endif
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    vec++;
    if (count !== 7'd10 || r_data !== 8'h10) begin
      errs++;
      $display("FAIL flush_load: count=%0d r_data=%h want 10 10", count, r_data);
    end
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    vec++;
    if (count !== 7'd0 || empty !== 1'b1 || r_data !== 8'h00) begin
      errs++;
      $display("FAIL flush: count=%0d empty=%b r_data=%h want 0 1 00",
               count, empty, r_data);
    end
`ifdef TX_DATA_BUFFER_ERR_EN
    vec++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL flush_err: err=%b want 0", err);
    end
`endif
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    vec++;
    if (count !== 7'd2 || r_data !== 8'h77) begin
      errs++;
      $display("FAIL post_flush: count=%0d r_data=%h want 2 77", count, r_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vec++;
    if (r_data !== 8'h78) begin
      errs++;
      $display("FAIL post_flush_pop: r_data=%h want 78", r_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    vec++;
    if (count !== 7'd5 || r_data !== 8'hC0) begin
      errs++;
      $display("FAIL arst_load: count=%0d r_data=%h want 5 c0", count, r_data);
    end
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if (count !== 7'd0 || empty !== 1'b1 || r_data !== 8'h00 || full !== 1'b0) begin
      errs++;
      $display("FAIL arst: count=%0d empty=%b r_data=%h full=%b want 0 1 00 0",
               count, empty, r_data, full);
    end
    #1;
    rst = 1'b0;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    vec++;
    if (count !== 7'd1 || r_data !== 8'h42) begin
      errs++;
      $display("FAIL arst_after: count=%0d r_data=%h want 1 42", count, r_data);
    end
  endtask

  initial begin
    vec      = 0;
    errs     = 0;
    rst      = 1'b1;
    w_enable = 1'b0;
    w_data   = 8'h00;
    r_enable = 1'b0;
    flush    = 1'b0;
    test_reset();
    test_basic();
    test_fill_drain();
    test_full_both();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
